// File: rtl/muldiv_sequencer.sv
// EX-stage sequencer for the shared iterative multiply/divide unit.
// Stalls the front end for the op latency and strobes the writeback.
module muldiv_sequencer #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 64,
  parameter int CNT_W       = $clog2(DIV_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       issue,
  input  logic       mult,
  input  logic       div,
  input  logic [4:0] regRD,
  input  logic       divisor_zero,
  input  logic       flush,
  output logic       stall,
  output logic       unit_start,
  output logic       unit_op,
  output logic       busy,
  output logic       wb_valid,
  output logic [4:0] wb_reg,
  output logic       div_zero,
  output logic       abort
);

  localparam logic [CNT_W-1:0] MC  = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DC  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [4:0]       rd_q, rd_n;
  logic             op_q, op_n;
  logic             dz_q, dz_n;
  logic             first_q, first_n;
  logic             rst_q;

  logic stall_c, start_c, busy_c;
  logic wb_c, dz_c, abort_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rd_q    <= '0;
      op_q    <= 1'b0;
      dz_q    <= 1'b0;
      first_q <= 1'b0;
      rst_q   <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rd_q    <= rd_n;
      op_q    <= op_n;
      dz_q    <= dz_n;
      first_q <= first_n;
      rst_q   <= 1'b0;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rd_n    = rd_q;
    op_n    = op_q;
    dz_n    = dz_q;
    first_n = 1'b0;
    stall_c = 1'b0;
    start_c = 1'b0;
    busy_c  = 1'b0;
    wb_c    = 1'b0;
    dz_c    = 1'b0;
    abort_c = 1'b0;
    unique case (state)
      IDLE: begin
        // No accept in the first cycle out of reset: outputs stay quiet.
        if (issue & (mult | div) & ~flush & ~rst_q) begin
          stall_c = 1'b1;
          rd_n    = regRD;
          op_n    = ~mult;
          if (mult) begin
            cnt_n   = MC;
            state_n = RUN;
            first_n = 1'b1;
          end else if (divisor_zero) begin
            dz_n    = 1'b1;
            state_n = DONE;
          end else begin
            cnt_n   = DC;
            state_n = RUN;
            first_n = 1'b1;
          end
        end
      end
      RUN: begin
        stall_c = 1'b1;
        busy_c  = 1'b1;
        start_c = first_q;
        if (flush) begin
          abort_c = 1'b1;
          cnt_n   = '0;
          state_n = IDLE;
        end else if (cnt == ONE) begin
          state_n = DONE;
        end else begin
          cnt_n = cnt - ONE;
        end
      end
      DONE: begin
        busy_c  = 1'b1;
        wb_c    = ~flush;
        dz_c    = dz_q & ~flush;
        abort_c = flush;
        dz_n    = 1'b0;
        cnt_n   = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign stall      = stall_c & ~reset;
  assign unit_start = start_c & ~reset;
  assign busy       = busy_c & ~reset;
  assign wb_valid   = wb_c & ~reset;
  assign div_zero   = dz_c & ~reset;
  assign abort      = abort_c & ~reset;
  assign unit_op    = op_q & ~reset;
  assign wb_reg     = rd_q & {5{~reset}};

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, flush,
// divide-by-zero, back-to-back and reset cases.
module tb_muldiv_sequencer;

  localparam int MC = 4;
  localparam int DC = 64;

  logic       clk = 1'b0;
  logic       reset, issue, mult, div;
  logic       divisor_zero, flush;
  logic [4:0] regRD;
  logic       stall, unit_start, unit_op, busy;
  logic       wb_valid, div_zero, abort;
  logic [4:0] wb_reg;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  muldiv_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .issue        (issue),
    .mult         (mult),
    .div          (div),
    .regRD        (regRD),
    .divisor_zero (divisor_zero),
    .flush        (flush),
    .stall        (stall),
    .unit_start   (unit_start),
    .unit_op      (unit_op),
    .busy         (busy),
    .wb_valid     (wb_valid),
    .wb_reg       (wb_reg),
    .div_zero     (div_zero),
    .abort        (abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive(input logic i, input logic m,
                       input logic d, input logic z,
                       input logic f, input logic [4:0] rd);
    issue        = i;
    mult         = m;
    div          = d;
    divisor_zero = z;
    flush        = f;
    regRD        = rd;
  endtask

  task automatic chk_all(input string tag,
                         input bit st, input bit us,
                         input bit bz, input bit wv,
                         input bit dz, input bit ab,
                         input bit op_e,
                         input logic [4:0] rd_e);
    chk({tag, ".stall"}, 32'(stall), 32'(st));
    chk({tag, ".start"}, 32'(unit_start), 32'(us));
    chk({tag, ".busy"}, 32'(busy), 32'(bz));
    chk({tag, ".wb"}, 32'(wb_valid), 32'(wv));
    chk({tag, ".dz"}, 32'(div_zero), 32'(dz));
    chk({tag, ".abort"}, 32'(abort), 32'(ab));
    if (bz) chk({tag, ".op"}, 32'(unit_op), 32'(op_e));
    if (wv) chk({tag, ".rd"}, 32'(wb_reg), 32'(rd_e));
  endtask

  task automatic idle(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      step();
      drive(0, 0, 0, 0, 0, 5'd0);
      #1;
      chk_all($sformatf("%s.i%0d", tag, k),
              0, 0, 0, 0, 0, 0, 0, 5'd0);
    end
  endtask

  // fl: flush offset from accept cycle, -1 for none.
  task automatic op(input string tag,
                    input logic m, input logic d,
                    input logic z, input logic [4:0] rd,
                    input int fl, output int wb_cyc);
    bit zero;
    int done_k;
    bit act, st, us, bz, wv, dz, ab;
    zero   = z && !m;
    done_k = zero ? 1 : (m ? MC : DC) + 1;
    wb_cyc = -1;
    for (int k = 0; k <= done_k; k++) begin
      act = (fl < 0) || (k <= fl);
      step();
      if (k == 0)
        drive(1, m, d, z, fl == 0, rd);
      else if (act)
        drive(1, k % 2 == 1, k % 2 == 0, 1, k == fl, ~rd);
      else
        drive(0, 0, 0, 0, 0, 5'd0);
      #1;
      st = act && k < done_k && !(k == 0 && fl == 0);
      us = act && !zero && k == 1 && fl != 0;
      bz = act && k >= 1;
      wv = act && k == done_k && k != fl;
      dz = wv && zero;
      ab = k == fl && fl >= 1;
      chk_all($sformatf("%s.k%0d", tag, k),
              st, us, bz, wv, dz, ab, !m, rd);
      if (wv) wb_cyc = cyc;
      if (fl == 0) break;
    end
  endtask

  initial begin
    int w0, w1, w2;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 5'd0);
    step();
    #1 chk_all("rst0", 0, 0, 0, 0, 0, 0, 0, 5'd0);
    step();
    drive(1, 1, 0, 0, 0, 5'd7);
    #1 chk_all("rst1", 0, 0, 0, 0, 0, 0, 0, 5'd0);
    chk("rst1.wb_reg", 32'(wb_reg), 32'd0);
    step();
    reset = 1'b0;
    #1 chk_all("postrst", 0, 0, 0, 0, 0, 0, 0, 5'd0);
    chk("postrst.op", 32'(unit_op), 32'd0);
    idle("pre", 3);

    op("mul", 1, 0, 0, 5'd7, -1, w0);
    idle("mul", 1);
    op("div", 0, 1, 0, 5'd3, -1, w0);
    op("dz", 0, 1, 1, 5'd9, -1, w0);
    idle("dz", 1);
    op("flrun", 1, 0, 0, 5'd12, 2, w0);
    idle("flrun", 6);
    op("fldone", 1, 0, 0, 5'd13, 5, w0);
    op("flacc", 1, 0, 0, 5'd2, 0, w0);
    idle("flacc", 1);
    op("dzfl", 0, 1, 1, 5'd17, 1, w0);
    op("both", 1, 1, 0, 5'd21, -1, w0);
    idle("both", 1);

    op("b2b4", 1, 0, 0, 5'd4, -1, w1);
    op("b2b5", 1, 0, 0, 5'd5, -1, w2);
    chk("b2b.spacing", 32'(w2 - w1), 32'(MC + 2));
    idle("b2b", 1);

    step();
    drive(1, 0, 1, 0, 0, 5'd3);
    #1 chk("rdiv.acc", 32'(stall), 32'd1);
    for (int k = 1; k < 20; k++) begin
      step();
      drive(0, 0, 0, 0, 0, 5'd0);
      #1 chk($sformatf("rdiv.run%0d", k), 32'(busy), 32'd1);
    end
    step();
    reset = 1'b1;
    #1 chk_all("rdiv.rst", 0, 0, 0, 0, 0, 0, 0, 5'd0);
    chk("rdiv.rst.op", 32'(unit_op), 32'd0);
    step();
    reset = 1'b0;
    #1 chk_all("rdiv.post", 0, 0, 0, 0, 0, 0, 0, 5'd0);
    chk("rdiv.post.rd", 32'(wb_reg), 32'd0);
    chk("rdiv.post.op", 32'(unit_op), 32'd0);
    idle("rdiv", 70);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Sequences the shared iterative multiply/divide unit in the EX stage of the in-order pipeline.
- Takes the decoder's mult/div strobes and destination register and starts the unit.
- Stalls the front of the pipeline for the operation's fixed latency, then issues a one-cycle writeback strobe to the register-file write path.
- Handles flush (abort) and divide-by-zero short-circuit.

Parameters:
MULT_CYCLES, 4, busy cycles for a multiply (>=1)
DIV_CYCLES, 64, busy cycles for a divide, one quotient bit per cycle (>=1)
CNT_W, $clog2(DIV_CYCLES+1), width of the internal cycle counter (must hold max(MULT_CYCLES, DIV_CYCLES))

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
issue  in  1  valid instruction present in EX this cycle
mult  in  1  decoder mult strobe for the EX instruction
div  in  1  decoder div strobe for the EX instruction
regRD  in  5  destination register of the EX instruction
divisor_zero  in  1  EX operand B == 0, sampled only on divide accept
flush  in  1  pipeline flush (branch redirect) this cycle
stall  out  1  hold PC, IF/ID and ID/EX registers
unit_start  out  1  one-cycle start pulse to the iterative unit
unit_op  out  1  0 = multiply, 1 = divide; valid while busy
busy  out  1  operation in flight (RUN or DONE)
wb_valid  out  1  one-cycle result-write strobe
wb_reg  out  5  latched destination register, valid with wb_valid
div_zero  out  1  with wb_valid: divide by zero; datapath writes 0
abort  out  1  one-cycle pulse: operation killed by flush

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on posedge clk.
  - reset has priority over every other input.
  - On reset: state = IDLE, counter = 0, wb_reg = 0, unit_op = 0, dz flag = 0.
  - All outputs are 0 during reset and in the cycle after it.
- State IDLE:
  - Accept when issue & (mult | div) & ~flush.
  - If mult and div are both 1, treat as multiply (mult priority).
  - On accept, latch regRD into wb_reg and latch unit_op.
  - Multiply: counter <= MULT_CYCLES; next state RUN.
  - Divide with divisor_zero = 0: counter <= DIV_CYCLES; next state RUN.
  - Divide with divisor_zero = 1: next state DONE with dz flag set; unit_start is never pulsed.
  - stall = 1 combinationally in the accept cycle, so the instruction is held in EX.
- State RUN:
  - unit_start = 1 only in the first RUN cycle.
  - counter decrements each cycle.
  - When counter == 1, next state is DONE.
  - stall = 1 and busy = 1 throughout.
  - issue, mult and div are ignored.
- State DONE (exactly one cycle):
  - stall = 0, so the pipeline advances.
  - wb_valid = ~flush, combinational gate.
  - div_zero = dz flag & ~flush.
  - Next state IDLE; dz flag clears.
  - issue in DONE is ignored: the EX instruction is the completing one.
- Flush:
  - In RUN: next state IDLE and abort = 1 in that cycle; no wb_valid is ever produced for the operation.
  - In the IDLE accept cycle: no accept occurs and stall = 0.
  - In DONE: wb_valid is suppressed and abort = 1.
- Latency (accept in cycle T):
  - Multiply: unit_start at T+1, DONE/wb_valid at T+MULT_CYCLES+1, stall high for T..T+MULT_CYCLES.
  - Divide: the same with DIV_CYCLES.
  - Divide by zero: wb_valid at T+1, stall high at T only.
- Back-to-back operations:
  - A new mult/div can be accepted in the cycle after DONE.
  - Minimum spacing between wb_valid pulses is MULT_CYCLES+2.
- Reset mid-operation: returns to IDLE next cycle with no wb_valid and no abort.
- The counter never underflows; at counter == 1 it is not decremented further before DONE.

Test Plan:
- Multiply: reset, then issue = 1, mult = 1, regRD = 7 at cycle 10.
  - stall high cycles 10–14, unit_start at 11, unit_op = 0.
  - wb_valid = 1 with wb_reg = 7 at cycle 15; stall = 0 at 15; busy low at 16.
- Divide: issue, div, regRD = 3, divisor_zero = 0 at cycle 10.
  - stall high 10–74, unit_start at 11, unit_op = 1.
  - wb_valid with wb_reg = 3 and div_zero = 0 at 75.
- Divide by zero: div with divisor_zero = 1, regRD = 9 at cycle 10.
  - stall at 10 only, no unit_start.
  - wb_valid = 1, div_zero = 1, wb_reg = 9 at 11.
- Flush during run: multiply accepted at cycle 10, flush = 1 at cycle 12.
  - abort pulse at 12, state IDLE at 13, stall = 0 at 13.
  - No wb_valid is seen through cycle 20.
- Flush in DONE: multiply accepted at cycle 10, flush = 1 at cycle 15.
  - wb_valid = 0 and abort = 1 at 15.
- Overlap and reset:
  - mult = div = 1 accepted: behaves as multiply (wb_valid 5 cycles later).
  - Two multiplies with regRD 4 then 5: wb_valid pulses with wb_reg 4 and 5 at least 6 cycles apart.
  - reset asserted at cycle 30 mid-divide: all outputs 0 at 31, no wb_valid afterwards.
